// File: rtl/ring_entry_buf.sv
// ring_entry_buf
// Ring entry node for the core-to-core message ring. Ring traffic is
// forwarded with a fixed one-cycle latency. Local packets are buffered in a
// DEPTH-entry FIFO and injected onto the ring while this node holds the
// token. Up to MAX_PKTS complete packets are sent per token visit.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_reg_data/last/valid          local packet source
//   o_reg_ready                    local beat accepted when valid && ready
//   i_data/i_last/i_valid          upstream ring beat (no backpressure)
//   i_token                        single-cycle token pulse from upstream
//   o_data/o_last/o_valid          downstream ring beat (registered)
//   o_token                        single-cycle token pulse downstream (registered)
//   o_has_token                    high while the node owns the token
//   o_err                          sticky protocol-error flag
module ring_entry_buf #(
  parameter int   DW         = 8,
  parameter int   DEPTH      = 16,
  parameter int   MAX_PKTS   = 1,
  parameter logic TOKEN_INIT = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_reg_data,
  input  logic          i_reg_last,
  input  logic          i_reg_valid,
  output logic          o_reg_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  input  logic          i_valid,
  input  logic          i_token,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic          o_valid,
  output logic          o_token,
  output logic          o_has_token,
  output logic          o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_PKTS + 1);
  localparam logic [BW-1:0] BUDGET_INIT = BW'(MAX_PKTS);
  localparam logic [AW:0]   DEPTH_CNT   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {FWD, GRANT, SEND} state_t;

  state_t        state_reg;
  logic [BW-1:0] budget_reg;
  logic          tok_pend_reg;
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [AW:0]   pkt_cnt_reg;
  logic [DW:0]   mem [DEPTH];

  logic [AW:0]   used;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          pop_last;
  logic          head_last;
  logic [DW-1:0] head_data;
  logic          grant_now;
  logic          start_send;
  logic          sending;
  logic [BW-1:0] budget_cur;
  logic [BW-1:0] budget_dec;
  logic [AW:0]   pkt_cnt_next;

  always_comb begin
    used       = wr_ptr_reg - rd_ptr_reg;
    full       = (used == DEPTH_CNT);
    empty      = (used == '0);
    {head_last, head_data} = mem[rd_ptr_reg[AW-1:0]];
    push       = i_reg_valid && !full;
    // GRANT is never held for a whole cycle: the send/pass decision is taken
    // in the same cycle the token is sampled (or at the first edge after
    // reset when the node starts out owning the token).
    grant_now  = (state_reg == GRANT) || ((state_reg == FWD) && i_token);
    // A full FIFO without a complete packet must still be drained, otherwise
    // an overlong packet would deadlock the local source.
    start_send = grant_now && ((pkt_cnt_reg != '0) || full);
    sending    = start_send || (state_reg == SEND);
    pop        = sending && !empty;
    pop_last   = pop && head_last;
    budget_cur = (state_reg == SEND) ? budget_reg : BUDGET_INIT;
    budget_dec = budget_cur - 1'b1;
    pkt_cnt_next = pkt_cnt_reg + (AW+1)'(push && i_reg_last) - (AW+1)'(pop_last);
  end

  assign o_reg_ready = !full;
  assign o_has_token = (state_reg != FWD);

  // Payload storage is not reset; emptiness is carried by the pointers.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= {i_reg_last, i_reg_data};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= TOKEN_INIT ? GRANT : FWD;
      budget_reg   <= BUDGET_INIT;
      tok_pend_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      pkt_cnt_reg  <= '0;
      o_data       <= '0;
      o_last       <= 1'b0;
      o_valid      <= 1'b0;
      o_token      <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      pkt_cnt_reg <= pkt_cnt_next;

      if ((state_reg == SEND && i_valid) || (o_has_token && i_token)) begin
        o_err <= 1'b1;
      end

      if (sending) begin
        // Upstream ring beats are dropped here; an empty FIFO (overlong
        // packet still arriving) produces a bubble instead of leaving SEND.
        o_valid <= pop;
        o_data  <= pop ? head_data : '0;
        o_last  <= pop_last;
        o_token <= 1'b0;
        if (pop_last && ((budget_dec == '0) || (pkt_cnt_next == '0))) begin
          // Token leaves the cycle after the last injected beat.
          state_reg    <= FWD;
          tok_pend_reg <= 1'b1;
        end else begin
          state_reg  <= SEND;
          budget_reg <= pop_last ? budget_dec : budget_cur;
        end
      end else begin
        o_valid      <= i_valid;
        o_data       <= i_data;
        o_last       <= i_last;
        o_token      <= tok_pend_reg || grant_now;
        tok_pend_reg <= 1'b0;
        state_reg    <= FWD;
      end
    end
  end

endmodule

// File: tb/tb_ring_entry_buf.sv
// Testbench for ring_entry_buf. A queue-based reference model predicts every
// downstream ring event (beat and/or token) together with the cycle it must
// appear in; a separate monitor compares the DUT output against it.
module tb_ring_entry_buf;

  localparam int DW       = 8;
  localparam int DEPTH    = 8;
  localparam int MAX_PKTS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] reg_data, ring_data;
  logic          reg_last, reg_valid, ring_last, ring_valid, ring_token;
  logic          o_reg_ready;
  logic [DW-1:0] o_data;
  logic          o_last, o_valid, o_token, o_has_token, o_err;

  // Second instance that owns the token out of reset; its inputs stay idle.
  logic [DW-1:0] zero_data = '0;
  logic          zero_bit  = 1'b0;
  logic          ti_reg_ready, ti_last, ti_valid, ti_token, ti_has_token, ti_err;
  logic [DW-1:0] ti_data;

  int checks = 0;
  int errors = 0;
  int pcount = 0;

  typedef struct packed {
    int       cyc;
    bit       valid;
    bit [7:0] data;
    bit       last;
    bit       token;
  } ev_t;

  ev_t      exp_q[$];
  bit [8:0] m_q[$];
  bit       m_hold, m_pend, m_err;
  int       m_budget;
  int       tok_gap;

  always #5 clk = ~clk;

  ring_entry_buf #(.DW(DW), .DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS), .TOKEN_INIT(1'b0)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_reg_data(reg_data), .i_reg_last(reg_last), .i_reg_valid(reg_valid),
    .o_reg_ready(o_reg_ready),
    .i_data(ring_data), .i_last(ring_last), .i_valid(ring_valid), .i_token(ring_token),
    .o_data(o_data), .o_last(o_last), .o_valid(o_valid), .o_token(o_token),
    .o_has_token(o_has_token), .o_err(o_err)
  );

  ring_entry_buf #(.DW(DW), .DEPTH(4), .MAX_PKTS(1), .TOKEN_INIT(1'b1)) u_dut_ti (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_reg_data(zero_data), .i_reg_last(zero_bit), .i_reg_valid(zero_bit),
    .o_reg_ready(ti_reg_ready),
    .i_data(zero_data), .i_last(zero_bit), .i_valid(zero_bit), .i_token(zero_bit),
    .o_data(ti_data), .o_last(ti_last), .o_valid(ti_valid), .o_token(ti_token),
    .o_has_token(ti_has_token), .o_err(ti_err)
  );

  initial forever begin
    @(posedge clk);
    pcount = pcount + 1;
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (!ok) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, pcount);
    end
  endtask

  function automatic int count_lasts();
    int n = 0;
    foreach (m_q[i]) if (m_q[i][8]) n++;
    return n;
  endfunction

  // Reference model: one call per cycle, using the inputs driven this cycle,
  // predicts the ring output visible in the next cycle.
  task automatic model_step();
    bit       full, push, grant, send, did_pop;
    bit [8:0] popped;
    int       b;
    ev_t      e;
    full    = (m_q.size() == DEPTH);
    push    = reg_valid && !full;
    grant   = !m_hold && ring_token;
    send    = m_hold || (grant && (count_lasts() > 0 || full));
    did_pop = 1'b0;
    popped  = '0;
    if (m_hold && (ring_valid || ring_token)) m_err = 1'b1;
    if (send && m_q.size() > 0) begin
      popped  = m_q.pop_front();
      did_pop = 1'b1;
    end
    if (push) m_q.push_back({reg_last, reg_data});
    e = '0;
    e.cyc = pcount + 1;
    if (send) begin
      e.valid = did_pop;
      e.data  = popped[7:0];
      e.last  = popped[8];
      b = m_hold ? m_budget : MAX_PKTS;
      if (did_pop && popped[8]) begin
        b = b - 1;
        if (b == 0 || count_lasts() == 0) begin
          m_hold = 1'b0;
          m_pend = 1'b1;
        end else begin
          m_hold   = 1'b1;
          m_budget = b;
        end
      end else begin
        m_hold   = 1'b1;
        m_budget = b;
      end
    end else begin
      e.valid = ring_valid;
      e.data  = ring_data;
      e.last  = ring_last;
      e.token = m_pend || grant;
      m_pend  = 1'b0;
      if (e.token) tok_gap = 0;
    end
    if (e.valid || e.token) exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_hold   = 1'b0;
    m_pend   = 1'b0;
    m_err    = 1'b0;
    m_budget = MAX_PKTS;
    tok_gap  = 10;
  endtask

  // Drive one cycle of inputs; called at posedge+1, returns at next posedge+1.
  task automatic step(input bit rv, input bit [7:0] rd, input bit rl,
                      input bit iv, input bit [7:0] id, input bit il, input bit it);
    chk(o_reg_ready == (m_q.size() < DEPTH), "o_reg_ready", o_reg_ready, (m_q.size() < DEPTH));
    reg_valid = rv; reg_data = rd; reg_last = rl;
    ring_valid = iv; ring_data = id; ring_last = il; ring_token = it;
    model_step();
    tok_gap = tok_gap + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 8'h00, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic token();
    step(0, 8'h00, 0, 0, 8'h00, 0, 1);
  endtask

  // Monitor: compares whatever the DUT presents against the predicted event.
  initial forever begin
    ev_t e;
    @(negedge clk);
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < pcount) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].cyc == pcount) begin
        e = exp_q.pop_front();
        $display("cyc %0d ring out: valid=%0b data=%02h last=%0b token=%0b",
                 pcount, o_valid, o_data, o_last, o_token);
        chk(o_valid == e.valid, "o_valid", o_valid, e.valid);
        chk(o_token == e.token, "o_token", o_token, e.token);
        if (e.valid) begin
          chk(o_data == e.data, "o_data", o_data, e.data);
          chk(o_last == e.last, "o_last", o_last, e.last);
        end
      end else if (o_valid || o_token) begin
        chk(!(o_valid || o_token), "unexpected_out", {o_valid, o_token}, 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk(o_data == '0,     {tag, "_o_data"},  o_data, 0);
    chk(o_valid == 1'b0,  {tag, "_o_valid"}, o_valid, 0);
    chk(o_last == 1'b0,   {tag, "_o_last"},  o_last, 0);
    chk(o_token == 1'b0,  {tag, "_o_token"}, o_token, 0);
    chk(o_err == 1'b0,    {tag, "_o_err"},   o_err, 0);
    chk(o_reg_ready == 1'b1, {tag, "_ready"}, o_reg_ready, 1);
    chk(o_has_token == 1'b0, {tag, "_has_token"}, o_has_token, 0);
  endtask

  initial begin
    bit it, iv;
    rst_n = 1'b0;
    reg_valid = 0; reg_data = 0; reg_last = 0;
    ring_valid = 0; ring_data = 0; ring_last = 0; ring_token = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk(ti_has_token == 1'b1, "ti_has_token_reset", ti_has_token, 1);
    chk(ti_token == 1'b0, "ti_token_reset", ti_token, 0);
    rst_n = 1'b1;
    idle(1);
    chk(ti_token == 1'b1, "ti_token_first_edge", ti_token, 1);
    chk(ti_has_token == 1'b0, "ti_has_token_after", ti_has_token, 0);
    idle(1);
    chk(ti_token == 1'b0, "ti_token_single_pulse", ti_token, 0);

    // Pure forwarding with one token.
    for (int k = 0; k < 20; k++) begin
      step(0, 8'h00, 0, $urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), k == 10);
    end
    idle(3);

    // Single three-beat packet.
    step(1, 8'h11, 0, 0, 8'h00, 0, 0);
    step(1, 8'h22, 0, 0, 8'h00, 0, 0);
    step(1, 8'h33, 1, 0, 8'h00, 0, 0);
    idle(1);
    token();
    idle(6);

    // Burst limit: three two-beat packets, two per token visit.
    for (int p = 0; p < 3; p++) begin
      step(1, 8'(8'hA0 + 2 * p), 0, 0, 8'h00, 0, 0);
      step(1, 8'(8'hA1 + 2 * p), 1, 0, 8'h00, 0, 0);
    end
    idle(1);
    token();
    idle(8);
    token();
    idle(6);

    // Randomised traffic.
    for (int k = 0; k < 300; k++) begin
      it = !m_hold && !m_pend && tok_gap > 3 && ($urandom_range(0, 11) == 0);
      iv = !m_hold && !it && $urandom_range(0, 1);
      step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 2) == 0,
           iv, 8'($urandom), $urandom_range(0, 1), it);
    end

    // Close any open packet, then drain the FIFO with tokens.
    for (int k = 0; k < 40 && !(m_q.size() > 0 && m_q[m_q.size()-1][8]) && m_q.size() > 0; k++) begin
      step(1, 8'h5A, 1, 0, 8'h00, 0, 0);
    end
    for (int k = 0; k < 200 && (m_q.size() > 0 || m_hold || m_pend); k++) begin
      if (!m_hold && !m_pend && tok_gap > 3) token();
      else idle(1);
    end
    idle(4);

    // Backpressure / overlong packet: 10 beats into an 8-entry FIFO.
    for (int k = 0; k < 10; k++) step(1, 8'(8'hB0 + k), 0, 0, 8'h00, 0, 0);
    token();
    idle(2);
    step(1, 8'hBE, 0, 0, 8'h00, 0, 0);
    idle(3);
    step(1, 8'hBF, 1, 0, 8'h00, 0, 0);
    idle(8);

    // Protocol error: ring beat arrives while sending.
    for (int k = 0; k < 4; k++) step(1, 8'(8'hC0 + k), k == 3, 0, 8'h00, 0, 0);
    token();
    idle(1);
    step(0, 8'h00, 0, 1, 8'hEE, 1, 0);
    idle(1);
    chk(o_err == m_err, "o_err_set", o_err, m_err);
    idle(6);
    chk(o_err == m_err, "o_err_sticky", o_err, m_err);

    // Asynchronous reset in the middle of a packet.
    for (int k = 0; k < 4; k++) step(1, 8'(8'hD0 + k), k == 3, 0, 8'h00, 0, 0);
    token();
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reg_valid = 0; ring_valid = 0; ring_token = 0;

    // Function after reset: the discarded packet must not reappear.
    step(1, 8'h71, 0, 0, 8'h00, 0, 0);
    step(1, 8'h72, 1, 0, 8'h00, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 8'h00, 0, 1, 8'(8'h80 + k), k == 4, 0);
    token();
    idle(6);
    chk(o_err == m_err, "o_err_after_reset", o_err, m_err);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
